// File: rtl/pcnn_pkg.sv
// Shared types and default geometry for the PCNN iteration scheduler.
package pcnn_pkg;

  localparam int unsigned ROWS_DEF   = 8;
  localparam int unsigned COLS_DEF   = 8;
  localparam int unsigned ADDR_W_DEF = 6;
  localparam int unsigned CNT_W_DEF  = 7;
  localparam int unsigned ITER_W_DEF = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CONV_GO   = 3'd1,
    CONV_WAIT = 3'd2,
    UPD       = 3'd3,
    DRAIN     = 3'd4,
    ITER_END  = 3'd5,
    FINISH    = 3'd6
  } state_t;

  // Index width for a counter spanning n positions (at least one bit).
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pcnn_iter_sched_if.sv
// Host, convolution and neuron-update signals of the PCNN iteration scheduler.
interface pcnn_iter_sched_if
  import pcnn_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned ITER_W = ITER_W_DEF
);

  logic              start;
  logic              abort;
  logic [ITER_W-1:0] max_iter;
  logic              conv_go;
  logic              conv_done;
  logic              upd_en;
  logic [ADDR_W-1:0] upd_addr;
  logic              fire;
  logic              buf_sel;
  logic [ITER_W-1:0] iter;
  logic [CNT_W-1:0]  fire_cnt;
  logic              busy;
  logic              done;

  // master: the scheduler; slave: host plus convolution/neuron datapaths
  modport master (
    input  start, abort, max_iter, conv_done, fire,
    output conv_go, upd_en, upd_addr, buf_sel, iter, fire_cnt, busy, done
  );

  modport slave (
    output start, abort, max_iter, conv_done, fire,
    input  conv_go, upd_en, upd_addr, buf_sel, iter, fire_cnt, busy, done
  );

endinterface

// File: rtl/pcnn_pix_counter.sv
// Row/column pixel sweep counter producing the linear address row*COLS+col.
module pcnn_pix_counter
  import pcnn_pkg::*;
#(
  parameter int unsigned ROWS   = ROWS_DEF,
  parameter int unsigned COLS   = COLS_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_en,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);

  localparam int unsigned ROW_W = idx_w(ROWS);
  localparam int unsigned COL_W = idx_w(COLS);

  logic [ROW_W-1:0]  r_row;
  logic [COL_W-1:0]  r_col;
  logic [ADDR_W-1:0] r_addr;
  logic              w_row_last;
  logic              w_col_last;

  assign w_row_last = (r_row == ROW_W'(ROWS - 1));
  assign w_col_last = (r_col == COL_W'(COLS - 1));

  // Linear address kept alongside row/col so no multiplier is needed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_row  <= '0;
      r_col  <= '0;
      r_addr <= '0;
    end else if (i_clr) begin
      r_row  <= '0;
      r_col  <= '0;
      r_addr <= '0;
    end else if (i_en) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
      r_addr <= o_last ? '0 : r_addr + ADDR_W'(1);
    end
  end

  assign o_addr = r_addr;
  assign o_last = w_row_last & w_col_last;

endmodule

// File: rtl/pcnn_iter_sched.sv
// PCNN iteration scheduler: conv start/wait, per-pixel neuron sweep, fire count, buffer flip.
// Optional PCNN_EARLY_STOP_EN: an iteration with zero fires ends the run.
module pcnn_iter_sched
  import pcnn_pkg::*;
#(
  parameter int unsigned ROWS   = ROWS_DEF,
  parameter int unsigned COLS   = COLS_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned ITER_W = ITER_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  pcnn_iter_sched_if.master bus
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ITER_W-1:0] r_iter;
  logic [ITER_W-1:0] r_iter_lim;
  logic [CNT_W-1:0]  r_acc;
  logic [CNT_W-1:0]  r_fire_cnt;
  logic              r_buf_sel;
  logic              r_conv_go;
  logic              r_upd_en;
  logic              r_busy;
  logic              r_done;
  logic              r_fire_vld;

  logic              w_pix_clr;
  logic              w_pix_en;
  logic              w_pix_last;
  logic              w_stop;
  logic              w_run_accept;
  logic              w_iter_commit;
  logic [ADDR_W-1:0] w_pix_addr;

  pcnn_pix_counter #(
    .ROWS   (ROWS),
    .COLS   (COLS),
    .ADDR_W (ADDR_W)
  ) u_pix (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_pix_clr),
    .i_en   (w_pix_en),
    .o_addr (w_pix_addr),
    .o_last (w_pix_last)
  );

`ifdef PCNN_EARLY_STOP_EN
  assign w_stop = (r_iter == r_iter_lim) || (r_acc == '0);
`else
  assign w_stop = (r_iter == r_iter_lim);
`endif

  // Next-state decode; abort overrides every transition
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:      if (bus.start) w_state_nxt = CONV_GO;
      CONV_GO:   w_state_nxt = CONV_WAIT;
      CONV_WAIT: if (bus.conv_done) w_state_nxt = UPD;
      UPD:       if (w_pix_last) w_state_nxt = DRAIN;
      DRAIN:     w_state_nxt = ITER_END;
      ITER_END:  w_state_nxt = w_stop ? FINISH : CONV_GO;
      FINISH:    w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
    if (bus.abort) w_state_nxt = IDLE;
  end

  assign w_run_accept  = (r_state == IDLE) && (w_state_nxt == CONV_GO);
  assign w_iter_commit = (r_state == ITER_END) && (w_state_nxt != IDLE);
  assign w_pix_clr     = (r_state == CONV_WAIT) && (w_state_nxt == UPD);
  assign w_pix_en      = (r_state == UPD) && !bus.abort;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Strobes registered from the next state so they align with the state they decode
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_conv_go  <= 1'b0;
      r_upd_en   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_fire_vld <= 1'b0;
    end else begin
      r_conv_go  <= (w_state_nxt == CONV_GO);
      r_upd_en   <= (w_state_nxt == UPD);
      r_busy     <= (w_state_nxt != IDLE);
      r_done     <= (w_state_nxt == FINISH);
      r_fire_vld <= r_upd_en;
    end
  end

  // Iteration index and limit; max_iter of 0 is run as a single iteration
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_iter     <= '0;
      r_iter_lim <= '0;
    end else if (w_run_accept) begin
      r_iter     <= '0;
      r_iter_lim <= (bus.max_iter == '0) ? '0 : bus.max_iter - ITER_W'(1);
    end else if (w_iter_commit && !w_stop) begin
      r_iter     <= r_iter + ITER_W'(1);
    end
  end

  // Fire accumulator samples fire one cycle after each update strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc <= '0;
    end else if (w_pix_clr) begin
      r_acc <= '0;
    end else if (r_fire_vld && bus.fire) begin
      r_acc <= r_acc + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fire_cnt <= '0;
      r_buf_sel  <= 1'b0;
    end else if (w_iter_commit) begin
      r_fire_cnt <= r_acc;
      r_buf_sel  <= ~r_buf_sel;
    end
  end

  assign bus.conv_go  = r_conv_go;
  assign bus.upd_en   = r_upd_en;
  assign bus.upd_addr = w_pix_addr;
  assign bus.buf_sel  = r_buf_sel;
  assign bus.iter     = r_iter;
  assign bus.fire_cnt = r_fire_cnt;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;

endmodule

// File: tb/tb_pcnn_iter_sched.sv
// Directed/randomized bench for pcnn_iter_sched on a 4x4 image.
module tb_pcnn_iter_sched;

  localparam int unsigned ROWS   = 4;
  localparam int unsigned COLS   = 4;
  localparam int unsigned NPIX   = ROWS * COLS;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned ITER_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pcnn_iter_sched_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .ITER_W(ITER_W)) bus ();

  pcnn_iter_sched #(
    .ROWS(ROWS), .COLS(COLS), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .ITER_W(ITER_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  bit pat [0:15][0:NPIX-1];
  int m_buf = 0;
  int m_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int popc(input int k);
    int n = 0;
    for (int i = 0; i < NPIX; i++) n += int'(pat[k][i]);
    return n;
  endfunction

  // Place exactly n fires at random positions of iteration k
  task automatic set_count(input int k, input int n);
    bit t;
    int j;
    for (int i = 0; i < NPIX; i++) pat[k][i] = (i < n);
    for (int i = NPIX - 1; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      t = pat[k][i]; pat[k][i] = pat[k][j]; pat[k][j] = t;
    end
  endtask

  task automatic set_random(input int k);
    for (int i = 0; i < NPIX; i++) pat[k][i] = 1'($urandom);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_conv_go"},  32'(bus.conv_go),  0);
    chk({tag, "_upd_en"},   32'(bus.upd_en),   0);
    chk({tag, "_upd_addr"}, 32'(bus.upd_addr), 0);
    chk({tag, "_buf_sel"},  32'(bus.buf_sel),  0);
    chk({tag, "_iter"},     32'(bus.iter),     0);
    chk({tag, "_fire_cnt"}, 32'(bus.fire_cnt), 0);
    chk({tag, "_busy"},     32'(bus.busy),     0);
    chk({tag, "_done"},     32'(bus.done),     0);
  endtask

  // One run from start; iteration k starts at cycle k*(19+tconv) after the first conv_go
  task automatic run(input string tag, input int mi, input int tconv,
                     input int abort_addr, input bit noisy);
    int  n_exp, eff, n_go, n_upd, go_cyc, it, exp_addr, prev_addr, n_done;
    bit  prev_upd, seen_done, aborted, addr_ok, busy_ok;
    eff = (mi == 0) ? 1 : mi;
    n_exp = eff;
`ifdef PCNN_EARLY_STOP_EN
    for (int k = 0; k < eff; k++) if (popc(k) == 0) begin n_exp = k + 1; break; end
`endif
    n_go = 0; n_upd = 0; go_cyc = -1; it = -1; exp_addr = 0; prev_addr = 0;
    prev_upd = 0; seen_done = 0; aborted = 0; addr_ok = 1; busy_ok = 1;

    bus.max_iter = ITER_W'(mi);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.max_iter = ITER_W'($urandom);

    for (int cyc = 0; cyc < 3000 && !seen_done && !aborted; cyc++) begin
      if (bus.busy !== 1'b1) busy_ok = 0;
      if (bus.conv_go) begin
        n_go++; it++; go_cyc = cyc;
        if (it > 0) begin m_cnt = popc(it - 1); m_buf ^= 1; end
        chk({tag, "_go_cycle"}, 32'(cyc), 32'(it * (19 + tconv)));
        chk({tag, "_go_iter"},  32'(bus.iter), 32'(it));
        chk({tag, "_go_fcnt"},  32'(bus.fire_cnt), 32'(m_cnt));
        chk({tag, "_go_buf"},   32'(bus.buf_sel), 32'(m_buf));
      end
      bus.abort = 1'b0;
      if (bus.upd_en) begin
        n_upd++;
        if (int'(bus.upd_addr) != exp_addr) addr_ok = 0;
        if (abort_addr >= 0 && it == 0 && int'(bus.upd_addr) == abort_addr) begin
          bus.abort = 1'b1; aborted = 1;
        end
        exp_addr = (exp_addr + 1) % NPIX;
      end
      if (bus.done) begin
        seen_done = 1;
        m_cnt = popc(it); m_buf ^= 1;
        chk({tag, "_done_cycle"}, 32'(cyc), 32'(n_exp * (19 + tconv)));
        chk({tag, "_done_iter"},  32'(bus.iter), 32'(n_exp - 1));
        chk({tag, "_done_fcnt"},  32'(bus.fire_cnt), 32'(m_cnt));
        chk({tag, "_done_buf"},   32'(bus.buf_sel), 32'(m_buf));
      end
      bus.fire = (prev_upd && it >= 0) ? pat[it][prev_addr] : 1'($urandom);
      bus.conv_done = (go_cyc >= 0 && cyc - go_cyc == tconv);
      if (noisy && bus.upd_en && ($urandom_range(3, 0) == 0)) bus.conv_done = 1'b1;
      bus.start = noisy ? 1'($urandom) : 1'b0;
      prev_upd = bus.upd_en;
      prev_addr = int'(bus.upd_addr);
      if (!seen_done && !aborted) step();
    end
    bus.start = 1'b0;
    bus.conv_done = 1'b0;

    if (aborted) begin
      step();
      bus.abort = 1'b0;
      chk({tag, "_abort_busy"},  32'(bus.busy), 0);
      chk({tag, "_abort_upd"},   32'(bus.upd_en), 0);
      chk({tag, "_abort_go"},    32'(bus.conv_go), 0);
      chk({tag, "_abort_fcnt"},  32'(bus.fire_cnt), 32'(m_cnt));
      chk({tag, "_abort_buf"},   32'(bus.buf_sel), 32'(m_buf));
      chk({tag, "_abort_iter"},  32'(bus.iter), 0);
      n_done = 0;
      for (int c = 0; c < 25; c++) begin
        bus.conv_done = 1'($urandom);
        bus.fire = 1'($urandom);
        step();
        n_done += int'(bus.done) + int'(bus.busy);
      end
      bus.conv_done = 1'b0;
      chk({tag, "_abort_quiet"}, 32'(n_done), 0);
    end else begin
      chk({tag, "_done_seen"}, 32'(seen_done), 1);
      chk({tag, "_n_go"},      32'(n_go), 32'(n_exp));
      chk({tag, "_n_upd"},     32'(n_upd), 32'(n_exp * NPIX));
      chk({tag, "_addr_seq"},  32'(addr_ok), 1);
      chk({tag, "_busy_run"},  32'(busy_ok), 1);
      step();
      chk({tag, "_post_done"}, 32'(bus.done), 0);
      chk({tag, "_post_busy"}, 32'(bus.busy), 0);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.max_iter = '0;
    bus.conv_done = 1'b0; bus.fire = 1'b0;
    for (int k = 0; k < 16; k++) set_random(k);

    step(); step();
    chk_all_zero("in_reset");
    @(negedge clk) rst = 1'b1;
    step();
    chk_all_zero("reset");

    // Spurious conv_done in IDLE, then start+abort together
    bus.conv_done = 1'b1; step(); bus.conv_done = 1'b0;
    chk("idle_conv_done_busy", 32'(bus.busy), 0);
    bus.start = 1'b1; bus.abort = 1'b1; bus.max_iter = 4'd2; step();
    bus.start = 1'b0; bus.abort = 1'b0;
    chk("start_abort_busy", 32'(bus.busy), 0);
    chk("start_abort_go",   32'(bus.conv_go), 0);
    step();
    chk("start_abort_go2",  32'(bus.conv_go), 0);

    run("single", 1, 3, -1, 1'b0);

    set_count(0, 5); set_count(1, 16);
    run("fires", 2, 1 + int'($urandom_range(4, 0)), -1, 1'b0);

    set_random(0);
    run("mi0", 0, 2, -1, 1'b0);

    set_random(0);
    run("abort", 3, 2, 7, 1'b0);
    set_random(0); set_random(1);
    run("after_abort", 2, 1, -1, 1'b1);

    set_count(0, 1 + int'($urandom_range(15, 0)));
    set_count(1, 0);
    for (int k = 2; k < 5; k++) set_count(k, 1 + int'($urandom_range(15, 0)));
    run("early", 5, 2, -1, 1'b0);

    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 4; k++) set_count(k, 1 + int'($urandom_range(15, 0)));
      run("rand", int'($urandom_range(4, 0)), 1 + int'($urandom_range(5, 0)), -1, 1'($urandom));
    end

    // Reset asserted mid-run returns every output to zero immediately
    bus.max_iter = 4'd3; bus.start = 1'b1; step(); bus.start = 1'b0;
    step(); bus.conv_done = 1'b1; step(); bus.conv_done = 1'b0;
    for (int c = 0; c < 6; c++) step();
    chk("mid_upd_en", 32'(bus.upd_en), 1);
    #2 rst = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    @(negedge clk) rst = 1'b1;
    m_buf = 0; m_cnt = 0;
    step();
    set_random(0);
    run("post_reset", 1, 1, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pcnn_iter_sched.md
# pcnn_iter_sched

Iteration scheduler for the PCNN image engine. It starts the convolution controller once per iteration with a `conv_go` pulse and waits for its `done`. It then sweeps the neuron-update stage across every pixel, counts fired neurons and flips the ping-pong pulse-image buffer. It repeats until the programmed iteration count is reached, and sits between the host start/status interface and the convolution and neuron datapaths.

## Interface
- `ROWS`, default 8: image rows.
- `COLS`, default 8: image columns.
- `ADDR_W`, default 6: pixel address width; must satisfy 2^ADDR_W >= ROWS*COLS.
- `CNT_W`, default 7: fire-count width; must satisfy 2^CNT_W > ROWS*COLS.
- `ITER_W`, default 4: iteration counter width.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin run; sampled only in IDLE.
- `abort`  in  1  synchronous abort, honoured in any state.
- `max_iter`  in  ITER_W  iteration count, latched on accepted `start`; 0 is treated as 1.
- `conv_go`  out  1  one-cycle start pulse to the convolution controller.
- `conv_done`  in  1  one-cycle completion pulse from the convolution controller.
- `upd_en`  out  1  neuron update strobe for `upd_addr`.
- `upd_addr`  out  ADDR_W  pixel index, row*COLS+col.
- `fire`  in  1  neuron fired; valid exactly 1 cycle after the matching `upd_en`.
- `buf_sel`  out  1  ping-pong pulse-buffer select.
- `iter`  out  ITER_W  index of the current iteration (0-based).
- `fire_cnt`  out  CNT_W  fire total of the last completed iteration.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.

## Operation
States and transitions:
- IDLE: `start` goes to CONV_GO, latches `max_iter`, clears `iter`.
- CONV_GO: `conv_go`=1 for this single cycle, then go to CONV_WAIT.
- CONV_WAIT: on `conv_done`, go to UPD; otherwise stay.
- UPD: `upd_en`=1 every cycle while `upd_addr` steps 0 to ROWS*COLS-1. The accumulator is cleared on UPD entry. After the last address, go to DRAIN.
- DRAIN: one cycle that captures the final `fire`.
- ITER_END:
  - Load `fire_cnt` from the accumulator and toggle `buf_sel`.
  - If `iter`==max_iter-1, go to FINISH.
  - Otherwise increment `iter` and go to CONV_GO.
- FINISH: `done`=1 for one cycle, then go to IDLE.

Arithmetic and counters:
- The accumulator adds `fire` on the cycle after each `upd_en`.
- It cannot overflow given the CNT_W rule.
- `iter` stays below max_iter, so it never wraps.

Reset: all outputs are 0, including `buf_sel`, `upd_addr`, `iter` and `fire_cnt`. State is IDLE.

Boundary conditions:
- `start` while busy: ignored.
- `conv_done` outside CONV_WAIT: ignored.
- `abort` in any state: go to IDLE next cycle.
  - `conv_go`, `upd_en` and `busy` drop to 0, and there is no `done` pulse.
  - `fire_cnt` and `buf_sel` hold their values; `iter` holds its value.
- `abort` and `conv_done` in the same cycle: abort wins.
- `abort` and `start` in IDLE in the same cycle: abort wins, and the run does not start.
- Reset asserted mid-run: everything returns to its reset value immediately.

## Timing
- `start` to `conv_go`: 1 cycle.
- `conv_done` to first `upd_en`: 1 cycle.
- Iteration length: 1 + Tconv + ROWS*COLS + 2 cycles, where Tconv is the CONV_WAIT dwell (≥1).
- `fire_cnt`/`buf_sel` update: the edge leaving ITER_END.
- `done`: 1 cycle after the final ITER_END.
- All outputs are registered or decoded from registered state only; there are no combinational input-to-output paths.

## Configuration
- `PCNN_EARLY_STOP_EN` defined: in ITER_END, a zero fire total also routes to FINISH. In that case `done` pulses and `iter` holds the stopping index.
- `PCNN_EARLY_STOP_EN` undefined: the run always completes max_iter iterations regardless of the fire total.

## Structure
- Package `pcnn_pkg`: the state enum type (IDLE, CONV_GO, CONV_WAIT, UPD, DRAIN, ITER_END, FINISH) and the default ROWS/COLS/width constants.
- Sub-module `pcnn_pix_counter`:
  - Row/column counter with clear and enable inputs.
  - Outputs `upd_addr` and a `last` flag.
  - Instantiated once.

## Test plan
All scenarios use ROWS=COLS=4.
- Reset/idle: hold `rst`=0, then release -> all outputs 0; `start` with max_iter=1 and `conv_done` 3 cycles after `conv_go` -> exactly 16 `upd_en` cycles with addresses 0..15, then a single `done`; total 1+3+18+1 cycles.
- Fire counting: max_iter=2, `fire` high on 5 pixels in iteration 0 and 16 pixels in iteration 1 -> `fire_cnt`=5 then 16; `buf_sel` reads 1 then 0; `conv_go` pulses twice.
- max_iter=0 -> behaves exactly as max_iter=1, giving one iteration.
- Abort during UPD at address 7 -> IDLE next cycle, no `done`, `upd_en` low; a new `start` then runs normally from iteration 0.
- Spurious `conv_done` in IDLE and in UPD, plus `start` pulses while busy -> no state change and no extra iteration.
- Early stop: with `PCNN_EARLY_STOP_EN` defined, max_iter=5 and zero fires in iteration 1 -> `done` after iteration 1 with `iter`=1. Without the macro, the same stimulus gives 5 iterations.
